// File: rtl/sobel_axis_out_buffer.sv
// sobel_axis_out_buffer: frame-syncing FWFT output FIFO for packed Sobel pixels with per-frame edge statistics
module sobel_axis_out_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int LANE_WIDTH = 8,
   parameter int FIFO_DEPTH = 1024,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  pixel_clk,
   input  logic                  reset,
   input  logic [LANE_WIDTH-1:0] edge_threshold,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [31:0]           frame_edge_count,
   output logic                  frame_stat_valid,
   output logic                  overflow,
   output logic                  frame_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam int PW = $clog2(IMG_WIDTH + 1) + 1;
   localparam int LW = $clog2(IMG_HEIGHT + 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_WIDTH - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 1);
   typedef enum logic [1:0] {WAIT_SOF, RUN, DROP} state_t;
   state_t state, state_nx;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic wrote_last, full, wr_en, rd_en, lost, flush;
   logic [PW-1:0] pix_cnt, pix_base;
   logic [LW-1:0] line_cnt, line_base;
   logic [31:0] edge_acc, acc_base, acc_sum;
   logic edge_bit, eof;

   assign full          = count == (AW+1)'(FIFO_DEPTH);
   assign s_axis_tready = !full;
   // an entry written on the previous edge is held back one cycle so the FIFO has a fixed 1-cycle latency
   assign m_axis_tvalid = count != '0 && !(count == (AW+1)'(1) && wrote_last);
   assign rd_en         = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      lost     = 1'b0;
      flush    = 1'b0;
      case (state)
         WAIT_SOF: if (s_axis_tvalid && s_axis_tuser) begin
            state_nx = RUN;
            wr_en    = !full;
            lost     = full;
         end
         RUN: if (s_axis_tvalid) begin
            state_nx = full ? DROP : RUN;
            wr_en    = !full;
            lost     = full;
            flush    = full;
         end
         default: if (s_axis_tvalid && s_axis_tuser) begin
            state_nx = full ? DROP : RUN;
            wr_en    = !full;
            lost     = full;
         end
      endcase
   end

   always_ff @(posedge pixel_clk) if (wr_en) mem[wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state      <= WAIT_SOF;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wrote_last <= 1'b0;
      end else begin
         state      <= state_nx;
         wr_ptr     <= wr_ptr + AW'(wr_en);
         rd_ptr     <= rd_ptr + AW'(rd_en);
         count      <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
         wrote_last <= wr_en;
      end
   end

   // a start-of-frame beat is pixel 0 of line 0, so it counts from a cleared base
   assign pix_base  = s_axis_tuser ? '0 : pix_cnt;
   assign line_base = s_axis_tuser ? '0 : line_cnt;
   assign acc_base  = s_axis_tuser ? '0 : edge_acc;
   assign edge_bit  = s_axis_tdata[2*LANE_WIDTH-1:LANE_WIDTH] > edge_threshold;
   assign acc_sum   = (&acc_base) ? acc_base : acc_base + 32'(edge_bit);
   assign eof       = s_axis_tlast && line_base == LINE_LAST;

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         pix_cnt          <= '0;
         line_cnt         <= '0;
         edge_acc         <= '0;
         frame_edge_count <= '0;
         frame_stat_valid <= 1'b0;
         overflow         <= 1'b0;
         frame_err        <= 1'b0;
      end else begin
         frame_stat_valid <= wr_en && eof;
         overflow         <= overflow | lost;
         if (flush) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            edge_acc <= '0;
         end else if (wr_en) begin
            frame_err <= frame_err
                       | (s_axis_tuser && (pix_cnt != '0 || line_cnt != '0))
                       | (s_axis_tlast && pix_base != PIX_LAST);
            pix_cnt   <= s_axis_tlast ? '0 : (&pix_base) ? pix_base : pix_base + PW'(1);
            line_cnt  <= !s_axis_tlast ? line_base : eof ? '0 : line_base + LW'(1);
            edge_acc  <= eof ? '0 : acc_sum;
            if (eof) frame_edge_count <= acc_sum;
         end
      end
   end
endmodule

// File: tb/tb_sobel_axis_out_buffer.sv
// tb_sobel_axis_out_buffer: directed vectors plus randomized traffic against a queue-based reference model
module tb_sobel_axis_out_buffer;
   localparam int DEPTH = 4;
   localparam int W = 4;
   localparam int H = 2;
   logic pixel_clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] edge_threshold = 8'h80;
   logic [31:0] s_axis_tdata = '0;
   logic s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
   logic s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tuser, m_axis_tlast;
   logic m_axis_tready = 1'b1;
   logic [31:0] frame_edge_count;
   logic frame_stat_valid, overflow, frame_err;

   sobel_axis_out_buffer #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .FIFO_DEPTH(DEPTH), .IMG_WIDTH(W), .IMG_HEIGHT(H)
   ) dut (
      .pixel_clk(pixel_clk), .reset(reset), .edge_threshold(edge_threshold),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .frame_edge_count(frame_edge_count), .frame_stat_valid(frame_stat_valid),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct { logic [33:0] w; int t; } ent_t;
   ent_t q[$];
   int mode, pix, line, cyc, n_cmp, n_bad, gp, gl, n, nst;
   longint eacc;
   logic [31:0] fec;
   bit err, ovf, stat, ev, ru, rl;

   // reference: mode 0 = hunting for SOF, 1 = passing, 2 = dropping rest of frame
   task automatic model_edge();
      bit rd, full, acc_b, lost;
      ent_t e;
      cyc++;
      if (reset) begin
         q.delete(); mode = 0; pix = 0; line = 0; eacc = 0; fec = 0;
         err = 0; ovf = 0; stat = 0; ev = 0;
         return;
      end
      rd = ev && m_axis_tready;
      full = q.size() == DEPTH;
      acc_b = 0; lost = 0;
      if (s_axis_tvalid) begin
         if (mode == 0 && s_axis_tuser) begin mode = 1; acc_b = !full; lost = full; end
         else if (mode == 1) begin
            if (full) begin lost = 1; mode = 2; pix = 0; line = 0; eacc = 0; end
            else acc_b = 1;
         end else if (mode == 2 && s_axis_tuser) begin
            if (full) lost = 1;
            else begin acc_b = 1; mode = 1; end
         end
      end
      if (rd) void'(q.pop_front());
      if (acc_b) begin e.w = {s_axis_tuser, s_axis_tlast, s_axis_tdata}; e.t = cyc; q.push_back(e); end
      if (lost) ovf = 1;
      stat = 0;
      if (acc_b) begin
         if (s_axis_tuser) begin
            if (pix != 0 || line != 0) err = 1;
            pix = 0; line = 0; eacc = 0;
         end
         if (s_axis_tdata[15:8] > edge_threshold) eacc = eacc + 1;
         if (eacc > 64'hFFFF_FFFF) eacc = 64'hFFFF_FFFF;
         if (s_axis_tlast) begin
            if (pix + 1 != W) err = 1;
            pix = 0; line++;
            if (line == H) begin fec = eacc[31:0]; stat = 1; line = 0; eacc = 0; end
         end else pix++;
      end
      ev = q.size() > 0 && q[0].t < cyc;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge pixel_clk);
      model_edge();
      #1;
      chk("m_tvalid", m_axis_tvalid, ev);
      chk("s_tready", s_axis_tready, q.size() != DEPTH);
      chk("overflow", overflow, ovf);
      chk("frame_err", frame_err, err);
      chk("stat_valid", frame_stat_valid, stat);
      chk("edge_count", frame_edge_count, fec);
      if (ev) begin
         chk("m_tdata", m_axis_tdata, q[0].w[31:0]);
         chk("m_tlast", m_axis_tlast, q[0].w[32]);
         chk("m_tuser", m_axis_tuser, q[0].w[33]);
      end
   endtask

   task automatic drv(logic v, logic u, logic l, logic [31:0] d);
      s_axis_tvalid = v; s_axis_tuser = u; s_axis_tlast = l; s_axis_tdata = d;
   endtask

   task automatic do_reset();
      reset = 1'b1; drv(0, 0, 0, 0); cycle(); reset = 1'b0;
   endtask

   typedef struct { logic v, u, l; logic [7:0] xy; logic ev, eu, el, es; logic [7:0] exy; } vec_t;
   vec_t tbl[13];
   logic [9:0] fe[12];

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      tbl[0]  = '{1, 0, 0, 8'h55, 0, 0, 0, 0, 8'h00};
      tbl[1]  = '{1, 0, 0, 8'h55, 0, 0, 0, 0, 8'h00};
      tbl[2]  = '{1, 0, 0, 8'h55, 0, 0, 0, 0, 8'h00};
      tbl[3]  = '{1, 1, 0, 8'h10, 0, 0, 0, 0, 8'h00};
      tbl[4]  = '{1, 0, 0, 8'h90, 1, 1, 0, 0, 8'h10};
      tbl[5]  = '{1, 0, 0, 8'h81, 1, 0, 0, 0, 8'h90};
      tbl[6]  = '{1, 0, 1, 8'h80, 1, 0, 0, 0, 8'h81};
      tbl[7]  = '{1, 0, 0, 8'hFF, 1, 0, 1, 0, 8'h80};
      tbl[8]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF};
      tbl[9]  = '{1, 0, 0, 8'h7F, 1, 0, 0, 0, 8'h00};
      tbl[10] = '{1, 0, 1, 8'h80, 1, 0, 0, 1, 8'h7F};
      tbl[11] = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h80};
      tbl[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00};
      fe = '{10'h200, 10'h000, 10'h100, 10'h000, 10'h2FF, 10'h0FF,
             10'h000, 10'h101, 10'h090, 10'h010, 10'h081, 10'h17F};
      cycle(); cycle();
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tready", s_axis_tready, 1);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_count", frame_edge_count, 0);
      chk("rst_flags", {overflow, frame_err, frame_stat_valid}, 0);
      reset = 1'b0;
      // pre-SOF discard, latency and tiny frame statistics
      for (int i = 0; i < 13; i++) begin
         drv(tbl[i].v, tbl[i].u, tbl[i].l, {8'hA0, 8'h0B, tbl[i].xy, 8'(i)});
         cycle();
         chk("tbl_tvalid", m_axis_tvalid, tbl[i].ev);
         chk("tbl_stat", frame_stat_valid, tbl[i].es);
         chk("tbl_count", frame_edge_count, i >= 10 ? 3 : 0);
         if (tbl[i].ev) begin
            chk("tbl_tdata", m_axis_tdata, {8'hA0, 8'h0B, tbl[i].exy, 8'(i - 1)});
            chk("tbl_tuser", m_axis_tuser, tbl[i].eu);
            chk("tbl_tlast", m_axis_tlast, tbl[i].el);
         end
      end
      // overflow into DROP, drain, resync on next SOF
      do_reset();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drv(1, i == 0, 0, 32'(i));
         cycle();
         if (i == 3) chk("full_tready", s_axis_tready, 0);
         if (i == 3) chk("ovf_before", overflow, 0);
         if (i == 4) chk("ovf_set", overflow, 1);
      end
      drv(0, 0, 0, 0);
      m_axis_tready = 1'b1;
      n = 0;
      repeat (8) begin
         if (m_axis_tvalid) n++;
         cycle();
      end
      chk("drain_count", n, 4);
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 32'h40 + 32'(i));
         cycle();
         chk("drop_discard", m_axis_tvalid, 0);
      end
      drv(1, 1, 0, 32'h77);
      cycle();
      chk("resync_latency", m_axis_tvalid, 0);
      drv(0, 0, 0, 0);
      cycle();
      chk("resync_valid", m_axis_tvalid, 1);
      chk("resync_data", m_axis_tdata, 32'h77);
      chk("resync_tuser", m_axis_tuser, 1);
      repeat (3) cycle();
      // steady simultaneous read/write at occupancy 2, then read+write while full
      do_reset();
      m_axis_tready = 1'b0;
      drv(1, 1, 0, 0); cycle();
      drv(1, 0, 0, 1); cycle();
      m_axis_tready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drv(1, 0, (k + 2) % 4 == 3, 32'(k + 2));
         cycle();
         chk("occ_tready", s_axis_tready, 1);
         chk("occ_order", m_axis_tdata, 32'(k + 1));
      end
      m_axis_tready = 1'b0;
      drv(1, 0, 0, 12); cycle();
      drv(1, 0, 0, 13); cycle();
      chk("occ_full", s_axis_tready, 0);
      m_axis_tready = 1'b1;
      drv(1, 0, 0, 14); cycle();
      chk("rw_full_ovf", overflow, 1);
      chk("rw_full_rejected", s_axis_tready, 1);
      drv(0, 0, 0, 0);
      repeat (6) cycle();
      // short line and mid-frame SOF, then a clean frame
      do_reset();
      nst = 0;
      for (int i = 0; i < 12; i++) begin
         drv(1, fe[i][9], fe[i][8], {16'h0, fe[i][7:0], 8'(i)});
         cycle();
         nst += int'(frame_stat_valid);
         if (i == 1) chk("err_clean", frame_err, 0);
         if (i == 2) chk("err_short", frame_err, 1);
         if (i == 11) chk("clean_stat", frame_stat_valid, 1);
         if (i == 11) chk("clean_count", frame_edge_count, 4);
      end
      drv(0, 0, 0, 0);
      repeat (4) begin cycle(); nst += int'(frame_stat_valid); end
      chk("one_pulse", nst, 1);
      chk("err_sticky", frame_err, 1);
      // reset mid-frame with three entries buffered
      m_axis_tready = 1'b0;
      drv(1, 1, 0, 32'h100); cycle();
      drv(1, 0, 0, 32'h101); cycle();
      drv(1, 0, 0, 32'h102); cycle();
      chk("pre_rst_valid", m_axis_tvalid, 1);
      do_reset();
      chk("mid_rst_tvalid", m_axis_tvalid, 0);
      chk("mid_rst_tready", s_axis_tready, 1);
      chk("mid_rst_count", frame_edge_count, 0);
      chk("mid_rst_flags", {overflow, frame_err, frame_stat_valid}, 0);
      m_axis_tready = 1'b1;
      drv(1, 0, 0, 32'h55); cycle(); cycle();
      chk("wait_sof_discard", m_axis_tvalid, 0);
      // randomized traffic with injected framing errors and backpressure bursts
      do_reset();
      edge_threshold = 8'($urandom_range(0, 255));
      gp = 0; gl = 0;
      for (int c = 0; c < 4000; c++) begin
         m_axis_tready = ((c / 64) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 8) begin
            ru = gp == 0 && gl == 0;
            rl = gp == W - 1;
            if ($urandom_range(0, 59) == 0) ru = 1;
            if ($urandom_range(0, 29) == 0) rl = 1;
            drv(1, ru, rl, $urandom());
            if (rl) begin gp = 0; gl = (gl == H - 1) ? 0 : gl + 1; end
            else gp++;
         end else drv(0, 0, 0, $urandom());
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
